// File: rtl/spi_byte_master.sv
// Single-byte SPI master, mode 0, with cs framing, busy and a one-cycle done pulse.
// Define SPI_BYTE_MASTER_LSB_FIRST_EN for LSB-first shifting; MSB-first otherwise.
module spi_byte_master #(
   parameter int DIV_FREQ_BY = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data,
   input  logic       load_data,
   input  logic       miso,
   output logic       mosi,
   output logic       cs,
   output logic       sck,
   output logic       busy,
   output logic [7:0] received_data,
   output logic       done
);

   localparam int unsigned H  = DIV_FREQ_BY / 2;
   localparam int unsigned PW = (H > 1) ? $clog2(H) : 1;

   typedef enum logic [2:0] {
      IDLE,
      LEAD,
      SHIFT_HI,
      SHIFT_LO,
      TRAIL
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [PW-1:0]   phase;
   logic            phase_end;
   logic [7:0]      tx_shift;
   logic [7:0]      rx_shift;
   logic [7:0]      tx_shifted;
   logic [7:0]      rx_shifted;
   logic            tx_bit;
   logic [2:0]      bit_cnt;
   logic            bit_last;

   assign phase_end = (phase == PW'(H - 1));

`ifdef SPI_BYTE_MASTER_LSB_FIRST_EN
   assign tx_bit     = tx_shift[0];
   assign tx_shifted = {1'b0, tx_shift[7:1]};
   assign rx_shifted = {miso, rx_shift[7:1]};
`else
   assign tx_bit     = tx_shift[7];
   assign tx_shifted = {tx_shift[6:0], 1'b0};
   assign rx_shifted = {rx_shift[6:0], miso};
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      busy       = 1'b1;
      cs         = 1'b0;
      sck        = 1'b0;
      mosi       = tx_bit;
      case (state)
         IDLE: begin
            busy = 1'b0;
            cs   = 1'b1;
            mosi = 1'b0;
            if (load_data) begin
               state_next = LEAD;
            end
         end
         LEAD: begin
            if (phase_end) begin
               state_next = SHIFT_HI;
            end
         end
         SHIFT_HI: begin
            sck = 1'b1;
            if (phase_end) begin
               state_next = bit_last ? TRAIL : SHIFT_LO;
            end
         end
         SHIFT_LO: begin
            if (phase_end) begin
               state_next = SHIFT_HI;
            end
         end
         TRAIL: begin
            if (phase_end) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
            busy       = 1'b0;
            cs         = 1'b1;
            mosi       = 1'b0;
         end
      endcase
   end

   // Shift/sample actions fire on the edge that enters the next phase, so
   // miso is captured as sck rises and mosi advances as sck falls.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase         <= '0;
         tx_shift      <= '0;
         rx_shift      <= '0;
         bit_cnt       <= '0;
         bit_last      <= 1'b0;
         received_data <= '0;
         done          <= 1'b0;
      end else begin
         done <= 1'b0;

         if (state_next != state) begin
            phase <= '0;
         end else if (state != IDLE) begin
            phase <= phase + 1'b1;
         end

         if (state == IDLE) begin
            if (load_data) begin
               tx_shift <= data;
               rx_shift <= '0;
               bit_cnt  <= '0;
               bit_last <= 1'b0;
            end
         end else if (phase_end) begin
            if (state_next == SHIFT_HI) begin
               rx_shift <= rx_shifted;
            end
            if (state_next == SHIFT_LO) begin
               tx_shift <= tx_shifted;
               bit_cnt  <= bit_cnt + 3'd1;
               bit_last <= (bit_cnt == 3'd6);
            end
            if (state_next == IDLE) begin
               received_data <= rx_shift;
               done          <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_byte_master.sv
// Directed bench for spi_byte_master at DIV_FREQ_BY=4 (H=2, frame = 34 busy cycles).
module tb_spi_byte_master;

   logic       clk;
   logic       rst;
   logic [7:0] data;
   logic       load_data;
   logic       miso;
   logic       mosi;
   logic       cs;
   logic       sck;
   logic       busy;
   logic [7:0] received_data;
   logic       done;

   logic       loopback;
   logic [7:0] slave_byte;
   int         sck_cnt;

   int vectors;
   int miscompares;

   int          busy_cnt, cs_low_cnt, sck_hi_cnt, sck_rises, done_cnt;
   int          done_first, done_last;
   logic [15:0] mosi_seq;
   logic [7:0]  rd_first, rd_last;
   logic        first_mosi;

   spi_byte_master #(.DIV_FREQ_BY(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .data         (data),
      .load_data    (load_data),
      .miso         (miso),
      .mosi         (mosi),
      .cs           (cs),
      .sck          (sck),
      .busy         (busy),
      .received_data(received_data),
      .done         (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Slave presents its byte MSB first, advancing after each rising sck.
   always @(posedge sck or posedge cs) begin
      if (cs) sck_cnt <= 0;
      else    sck_cnt <= sck_cnt + 1;
   end

   assign miso = loopback ? mosi : slave_byte[3'(7 - sck_cnt)];

   function automatic logic [7:0] wire_order(input logic [7:0] d);
      logic [7:0] r;
`ifdef SPI_BYTE_MASTER_LSB_FIRST_EN
      for (int i = 0; i < 8; i++) r[i] = d[7 - i];
`else
      r = d;
`endif
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic observe(input int ncyc, input int inj_at, input logic [7:0] inj_data, input int drop_at);
      logic prev_sck;
      busy_cnt = 0; cs_low_cnt = 0; sck_hi_cnt = 0; sck_rises = 0; done_cnt = 0;
      done_first = -1; done_last = -1; mosi_seq = '0; rd_first = '0; rd_last = '0;
      prev_sck = 1'b0;
      first_mosi = mosi;
      for (int m = 0; m < ncyc; m++) begin
         if (busy) busy_cnt++;
         if (!cs)  cs_low_cnt++;
         if (sck)  sck_hi_cnt++;
         if (sck && !prev_sck) begin
            sck_rises++;
            mosi_seq = {mosi_seq[14:0], mosi};
         end
         prev_sck = sck;
         if (done) begin
            done_cnt++;
            if (done_cnt == 1) begin
               done_first = m;
               rd_first   = received_data;
            end
            done_last = m;
            rd_last   = received_data;
         end
         if (m == inj_at) begin
            load_data = 1'b1;
            data      = inj_data;
         end
         if (m == drop_at) load_data = 1'b0;
         tick();
      end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      rst = 1'b1;
      load_data = 1'b0;
      data = 8'h00;
      loopback = 1'b1;
      slave_byte = 8'h00;

      tick(); tick(); tick();
      check("reset_cs",   32'(cs),            32'h1);
      check("reset_sck",  32'(sck),           32'h0);
      check("reset_mosi", 32'(mosi),          32'h0);
      check("reset_busy", 32'(busy),          32'h0);
      check("reset_done", 32'(done),          32'h0);
      check("reset_rd",   32'(received_data), 32'h00);
      rst = 1'b0;
      tick();

      // Basic loopback frame A5
      data = 8'hA5; load_data = 1'b1;
      tick();
      load_data = 1'b0;
      observe(40, -1, 8'h00, -1);
      check("basic_first_mosi", 32'(first_mosi), 32'h1);
      check("basic_busy_cnt",   32'(busy_cnt),   32'd34);
      check("basic_cs_low",     32'(cs_low_cnt), 32'd34);
      check("basic_sck_hi",     32'(sck_hi_cnt), 32'd16);
      check("basic_sck_rises",  32'(sck_rises),  32'd8);
      check("basic_mosi_seq",   32'(mosi_seq),   32'(wire_order(8'hA5)));
      check("basic_done_cnt",   32'(done_cnt),   32'd1);
      check("basic_done_at",    32'(done_first), 32'd34);
      check("basic_rd",         32'(rd_first),   32'hA5);

      // Independent slave data
      loopback = 1'b0; slave_byte = 8'h3C;
      data = 8'hFF; load_data = 1'b1;
      tick();
      load_data = 1'b0;
      observe(40, -1, 8'h00, -1);
      check("rx_mosi_seq", 32'(mosi_seq), 32'h00FF);
      check("rx_done_cnt", 32'(done_cnt), 32'd1);
      check("rx_rd",       32'(rd_first), 32'(wire_order(8'h3C)));
      loopback = 1'b1;

      // Load during a frame is ignored
      data = 8'hC3; load_data = 1'b1;
      tick();
      load_data = 1'b0;
      observe(45, 10, 8'h00, 11);
      check("ign_busy_cnt", 32'(busy_cnt), 32'd34);
      check("ign_done_cnt", 32'(done_cnt), 32'd1);
      check("ign_mosi_seq", 32'(mosi_seq), 32'(wire_order(8'hC3)));
      check("ign_rd",       32'(rd_first), 32'hC3);

      // Back-to-back with load_data held high
      data = 8'h01; load_data = 1'b1;
      tick();
      data = 8'h02;
      observe(75, -1, 8'h00, 35);
      check("b2b_done_cnt", 32'(done_cnt),             32'd2);
      check("b2b_spacing",  32'(done_last - done_first), 32'd35);
      check("b2b_cs_low",   32'(cs_low_cnt),           32'd68);
      check("b2b_busy_cnt", 32'(busy_cnt),             32'd68);
      check("b2b_mosi_seq", 32'(mosi_seq),             32'({wire_order(8'h01), wire_order(8'h02)}));
      check("b2b_rd_first", 32'(rd_first),             32'h01);
      check("b2b_rd_last",  32'(rd_last),              32'h02);

      // Reset in the middle of a frame
      data = 8'hA5; load_data = 1'b1;
      tick();
      load_data = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      check("midrst_busy_before", 32'(busy), 32'h1);
      rst = 1'b1;
      tick();
      check("midrst_cs",   32'(cs),            32'h1);
      check("midrst_busy", 32'(busy),          32'h0);
      check("midrst_sck",  32'(sck),           32'h0);
      check("midrst_mosi", 32'(mosi),          32'h0);
      check("midrst_done", 32'(done),          32'h0);
      check("midrst_rd",   32'(received_data), 32'h00);
      rst = 1'b0;
      observe(30, -1, 8'h00, -1);
      check("midrst_no_done", 32'(done_cnt), 32'd0);
      check("midrst_idle",    32'(busy_cnt), 32'd0);

      // Bit order of the first transmitted bit
      data = 8'h01; load_data = 1'b1;
      tick();
      load_data = 1'b0;
      observe(40, -1, 8'h00, -1);
`ifdef SPI_BYTE_MASTER_LSB_FIRST_EN
      check("order_first_mosi", 32'(first_mosi), 32'h1);
`else
      check("order_first_mosi", 32'(first_mosi), 32'h0);
`endif
      check("order_rd",       32'(rd_first), 32'h01);
      check("order_done_cnt", 32'(done_cnt), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
